axis_usb_packetizer: RTL and testbench
======================================

Name: axis_usb_packetizer

Overview:
- Sits in the `sys_clk` domain directly upstream of the bulk-IN AXIS slave port of the USB bridge.
- Converts an unframed or loosely framed byte stream into USB-sized packets:
  - asserts `m_axis_tlast` every MAX_PACKET bytes;
  - asserts it on an upstream `tlast`;
  - asserts it on an idle timeout or an explicit flush.
- Purpose: the host sees short packets promptly, and long streams are never left unterminated.

Parameters:
- MAX_PACKET, 512, maximum bytes per emitted packet (1..4096); must match the bulk IN `wMaxPacketSize`.
- TIMEOUT, 1024, idle `sys_clk` cycles before a pending byte is closed as a short packet; 0 disables the timeout.
- RESPECT_TLAST, 1, 1 = upstream `s_axis_tlast` terminates the packet; 0 = upstream `tlast` is ignored.

Ports:
- `sys_clk`  in  1  clock for all logic
- `reset_n`  in  1  synchronous active-low reset
- `flush_i`  in  1  level; forces the pending byte out as the end of a packet
- `s_axis_tvalid`  in  1  upstream byte valid
- `s_axis_tready`  out  1  upstream ready
- `s_axis_tdata`  in  8  upstream byte
- `s_axis_tlast`  in  1  upstream packet end
- `m_axis_tvalid`  out  1  to bridge `s_axis_tvalid`
- `m_axis_tready`  in  1  from bridge `s_axis_tready`
- `m_axis_tdata`  out  8  to bridge `s_axis_tdata`
- `m_axis_tlast`  out  1  to bridge `s_axis_tlast`
- `pkt_done_o`  out  1  one-cycle pulse on each `m_axis` beat with `tlast` handshaked
- `timeout_o`  out  1  one-cycle pulse when a packet was closed by timeout

Behaviour:
- **Reset.** All state is sampled on the `sys_clk` rising edge when `reset_n`=0. Reset values:
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0;
  - `s_axis_tready`=0 during reset;
  - `pkt_done_o`=0, `timeout_o`=0;
  - hold stage empty, `byte_cnt`=0, `idle_cnt`=0.
  - Reset mid-packet discards held and output bytes with no tlast emitted.
- **Two stages.**
  - Hold register H: `h_valid`, `h_data`, `h_tlast`.
  - Output register O drives `m_axis` directly, with no combinational input-to-output path.
- **Hold-stage FSM.**
  - EMPTY: `h_valid`=0.
  - HOLD: `h_valid`=1; waiting to learn whether the held byte ends a packet.
- **Transfer condition.**
  - `o_free` = ~`m_axis_tvalid` | `m_axis_tready`.
  - `end_cond` = (`byte_cnt` == MAX_PACKET-1) | (RESPECT_TLAST & `h_tlast`) | `to_hit` | `flush_i`.
  - `h_to_o` = `h_valid` & `o_free` & (`s_axis_tvalid` | `end_cond`).
  - On `h_to_o`: O takes `h_data`, and `m_axis_tlast` = `end_cond`.
- **Input ready.** `s_axis_tready` = ~`h_valid` | `h_to_o`. An input accept loads H.
- **FSM transitions.**
  - EMPTY→HOLD on accept.
  - HOLD→HOLD when `h_to_o` and accept occur together.
  - HOLD→EMPTY when `h_to_o` occurs without accept.
- **Output register.**
  - O is cleared (`m_axis_tvalid`=0) on `m_axis_tready` when no `h_to_o` occurs.
  - `m_axis_tdata`/`tlast` are stable while `m_axis_tvalid` & ~`m_axis_tready`.
- **Byte counter.**
  - `byte_cnt` width is clog2(MAX_PACKET)+1 bits.
  - On `h_to_o`: +1, or reset to 0 if `end_cond`.
  - Never exceeds MAX_PACKET-1; no wrap-around.
- **Idle counter.**
  - `idle_cnt` saturates at TIMEOUT.
  - Cleared on accept, on `h_to_o`, or when `h_valid`=0.
  - Otherwise increments while `h_valid`.
  - `to_hit` = (TIMEOUT!=0) & (`idle_cnt` == TIMEOUT).
- **Timeout pulse.** `timeout_o` = `h_to_o` & `to_hit` & ~(other end terms), registered one cycle.
- **Done pulse.** `pkt_done_o` = registered (`m_axis_tvalid` & `m_axis_tready` & `m_axis_tlast`).
- **Latency.** Minimum accept-to-`m_axis_tvalid` is 2 cycles for a continuing byte. A lone byte with RESPECT_TLAST tlast also takes 2 cycles.
- **Throughput.** 1 byte/cycle sustained when `m_axis_tready`=1.
- **Simultaneous events.**
  - Accept and `end_cond` in the same cycle: the held byte leaves with tlast=1, and the new byte starts the next packet with `byte_cnt`=0.
  - `flush_i` with H empty: no effect; zero-length packets are never generated.
- **Back-pressure.** While O is stalled, H holds and `idle_cnt` keeps counting. A timeout reached while stalled is applied when O frees.

Test Plan:
1. Reset: `reset_n`=0 for 3 cycles with `s_axis_tvalid`=1 → `s_axis_tready`=0, `m_axis_tvalid`=0, no beats out.
2. MAX_PACKET=512, continuous 1536 bytes 0x00..0xFF repeating, `tlast`=0, `m_axis_tready`=1 → tlast on output beats 512, 1024, 1536; 3 `pkt_done_o` pulses; data order preserved.
3. TIMEOUT=16, send 5 bytes then idle → 5th byte emitted with tlast=1 exactly 16 idle cycles after its accept, plus 1 cycle; `timeout_o` pulses once.
4. RESPECT_TLAST=1, packets of 3 and 700 bytes with `tlast` on the final byte → outputs 3 (tlast), 512 (tlast), 188 (tlast).
5. Random `m_axis_tready` (50%) over 2000 bytes → output stream equals input stream; tlast every 512; no `tvalid` drop or data change while stalled.
6. Assert `flush_i` after byte 10 with H full → byte 10 emitted with tlast; next byte starts a new count. Flush with H empty → no output.

Source files
------------

// File: rtl/axis_usb_packetizer_if.sv
// axis_usb_packetizer_if: byte-wide AXI-Stream bundle with master/slave views
interface axis_usb_packetizer_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_usb_packetizer.sv
// axis_usb_packetizer: cuts a byte stream into USB bulk-IN packets on size, upstream tlast, idle timeout or flush
module axis_usb_packetizer #(
    parameter int MAX_PACKET    = 512,
    parameter int TIMEOUT       = 1024,
    parameter int RESPECT_TLAST = 1
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    input  logic                         flush_i,
    axis_usb_packetizer_if.slave         s_axis,
    axis_usb_packetizer_if.master        m_axis,
    output logic                         pkt_done_o,
    output logic                         timeout_o
);
    localparam int CW = $clog2(MAX_PACKET) + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [7:0]    r_h_data;
    logic          r_h_tlast;
    logic [CW-1:0] r_byte_cnt;
    logic [TW-1:0] r_idle_cnt;
    logic          r_o_valid;
    logic [7:0]    r_o_data;
    logic          r_o_last;
    logic          r_pkt_done;
    logic          r_timeout;

    logic w_h_valid, w_o_free, w_cnt_end, w_tl_end, w_to_hit, w_end;
    logic w_h_to_o, w_s_ready, w_accept;

    assign w_h_valid = (r_state == HOLD);
    assign w_o_free  = ~r_o_valid | m_axis.tready;
    assign w_cnt_end = (r_byte_cnt == CW'(MAX_PACKET - 1));
    assign w_tl_end  = (RESPECT_TLAST != 0) & r_h_tlast;
    assign w_to_hit  = (TIMEOUT != 0) & (r_idle_cnt == TW'(TIMEOUT));
    assign w_end     = w_cnt_end | w_tl_end | w_to_hit | flush_i;
    // the held byte only moves once we know whether it closes the packet
    assign w_h_to_o  = w_h_valid & w_o_free & (s_axis.tvalid | w_end);
    assign w_s_ready = reset_n & (~w_h_valid | w_h_to_o);
    assign w_accept  = s_axis.tvalid & w_s_ready;

    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = r_o_valid;
    assign m_axis.tdata  = r_o_data;
    assign m_axis.tlast  = r_o_last;
    assign pkt_done_o    = r_pkt_done;
    assign timeout_o     = r_timeout;

    always_comb begin
        w_state_nx = w_accept ? HOLD : (w_h_to_o ? EMPTY : r_state);
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            r_state    <= EMPTY;
            r_h_data   <= '0;
            r_h_tlast  <= 1'b0;
            r_byte_cnt <= '0;
            r_idle_cnt <= '0;
            r_o_valid  <= 1'b0;
            r_o_data   <= '0;
            r_o_last   <= 1'b0;
            r_pkt_done <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_h_data  <= s_axis.tdata;
                r_h_tlast <= s_axis.tlast;
            end
            if (w_h_to_o) begin
                r_o_valid  <= 1'b1;
                r_o_data   <= r_h_data;
                r_o_last   <= w_end;
                r_byte_cnt <= w_end ? '0 : r_byte_cnt + CW'(1);
            end else if (m_axis.tready) begin
                r_o_valid <= 1'b0;
            end
            // idle time keeps accruing under back-pressure so a stalled timeout fires once O frees
            r_idle_cnt <= (w_accept | w_h_to_o | ~w_h_valid) ? '0 :
                          (r_idle_cnt == TW'(TIMEOUT)) ? r_idle_cnt : r_idle_cnt + TW'(1);
            r_timeout  <= w_h_to_o & w_to_hit & ~(w_cnt_end | w_tl_end | flush_i);
            r_pkt_done <= r_o_valid & m_axis.tready & r_o_last;
        end
    end
endmodule

// File: tb/tb_axis_usb_packetizer.sv
// tb_axis_usb_packetizer: random and directed stimulus against a packet-boundary reference model
module tb_axis_usb_packetizer;
    localparam int MAXP = 512;
    localparam int TO   = 16;

    typedef struct packed {logic [7:0] d; logic l;} beat_t;

    logic sys_clk, reset_n, flush_i, pkt_done_o, timeout_o;
    axis_usb_packetizer_if s_if();
    axis_usb_packetizer_if m_if();

    axis_usb_packetizer #(.MAX_PACKET(MAXP), .TIMEOUT(TO), .RESPECT_TLAST(1)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .flush_i(flush_i),
        .s_axis(s_if), .m_axis(m_if),
        .pkt_done_o(pkt_done_o), .timeout_o(timeout_o)
    );

    int    n_chk, n_err, cyc, n_beats, n_done, n_to;
    int    m_cnt, n_exp_last, n_exp_to, acc_cyc, last_cyc;
    bit    mon_en, rdy_mode, stall_prev, done_nx;
    int    stall_run;
    logic [8:0] prev_beat;
    beat_t exp_q[$];

    initial begin
        sys_clk = 0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial forever @(posedge sys_clk) cyc++;

    initial begin
        repeat (60000) @(posedge sys_clk);
        $display("FAIL watchdog cycles=%0d limit=60000", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // packet boundaries follow from byte counts and upstream tlast alone
    function automatic void model_push(input logic [7:0] d, input logic tl);
        beat_t b;
        m_cnt++;
        b.d = d;
        b.l = (m_cnt == MAXP) || tl;
        if (b.l) begin
            m_cnt = 0;
            n_exp_last++;
        end
        exp_q.push_back(b);
    endfunction

    function automatic void model_close(input bit by_to);
        if (exp_q.size() != 0 && !exp_q[exp_q.size()-1].l) begin
            exp_q[exp_q.size()-1].l = 1'b1;
            m_cnt = 0;
            n_exp_last++;
            if (by_to) n_exp_to++;
        end
    endfunction

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!rdy_mode) m_if.tready = 1'b1;
            else begin
                m_if.tready = ($urandom_range(0, 1) == 1) || (stall_run >= 6);
                stall_run   = m_if.tready ? 0 : stall_run + 1;
            end
        end
    end

    initial begin
        beat_t b;
        forever begin
            @(negedge sys_clk);
            if (mon_en) begin
                if (stall_prev) begin
                    chk("stall_valid", 32'(m_if.tvalid), 32'd1);
                    chk("stall_hold", 32'({m_if.tlast, m_if.tdata}), 32'(prev_beat));
                end
                chk("pkt_done", 32'(pkt_done_o), 32'(done_nx));
                n_done += 32'(pkt_done_o);
                n_to   += 32'(timeout_o);
                done_nx = m_if.tvalid & m_if.tready & m_if.tlast;
                if (m_if.tvalid && m_if.tready) begin
                    n_beats++;
                    if (m_if.tlast) last_cyc = cyc;
                    if (exp_q.size() == 0) chk("extra_beat", 32'({m_if.tlast, m_if.tdata}), 32'h200);
                    else begin
                        b = exp_q.pop_front();
                        chk("data", 32'(m_if.tdata), 32'(b.d));
                        chk("last", 32'(m_if.tlast), 32'(b.l));
                    end
                end
                stall_prev = m_if.tvalid & ~m_if.tready;
                prev_beat  = {m_if.tlast, m_if.tdata};
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        @(negedge sys_clk);
        while (!s_if.tready && n < 1000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 1000) chk("send_timeout", 32'(n), 32'd0);
        @(posedge sys_clk);
        #1;
        acc_cyc     = cyc;
        s_if.tvalid = 1'b0;
        model_push(d, l);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 300) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'(n), 32'd0);
        @(negedge sys_clk);
        @(posedge sys_clk);
        #1;
        chk("exp_empty", 32'(exp_q.size()), 32'd0);
        chk("done_total", 32'(n_done), 32'(n_exp_last));
        chk("timeout_total", 32'(n_to), 32'(n_exp_to));
    endtask

    initial begin
        int b0, d0, t0;
        reset_n     = 1'b0;
        flush_i     = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h5a;
        s_if.tlast  = 1'b0;
        repeat (3) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            chk("rst_s_tready", 32'(s_if.tready), 32'd0);
            chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
            chk("rst_pkt_done", 32'(pkt_done_o), 32'd0);
            chk("rst_timeout", 32'(timeout_o), 32'd0);
        end
        @(posedge sys_clk);
        #1;
        s_if.tvalid = 1'b0;
        reset_n     = 1'b1;
        mon_en      = 1'b1;

        b0 = n_beats; d0 = n_done;
        for (int i = 0; i < 1536; i++) send(8'(i), 1'b0);
        drain();
        chk("t2_beats", 32'(n_beats - b0), 32'd1536);
        chk("t2_pkts", 32'(n_done - d0), 32'd3);

        d0 = n_done;
        for (int i = 0; i < 3; i++) send(8'($urandom), i == 2);
        for (int i = 0; i < 700; i++) send(8'($urandom), i == 699);
        drain();
        chk("t4_pkts", 32'(n_done - d0), 32'd3);

        t0 = n_to;
        for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b0);
        model_close(1'b1);
        drain();
        chk("t3_latency", 32'(last_cyc - acc_cyc), 32'(TO + 1));
        chk("t3_timeout_pulse", 32'(n_to - t0), 32'd1);

        b0 = n_beats;
        rdy_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(8'($urandom), 1'b0);
        end
        model_close(1'b1);
        drain();
        rdy_mode = 1'b0;
        chk("t5_beats", 32'(n_beats - b0), 32'd2000);

        d0 = n_done;
        for (int i = 0; i < 10; i++) send(8'(8'h10 + i), 1'b0);
        flush_i = 1'b1;
        model_close(1'b0);
        idle(1);
        flush_i = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'h30 + i), i == 4);
        drain();
        chk("t6_pkts", 32'(n_done - d0), 32'd2);

        b0 = n_beats;
        flush_i = 1'b1;
        idle(5);
        chk("t6_empty_flush_valid", 32'(m_if.tvalid), 32'd0);
        flush_i = 1'b0;
        idle(3);
        chk("t6_empty_flush_beats", 32'(n_beats - b0), 32'd0);
        chk("t6_empty_flush_done", 32'(n_done), 32'(n_exp_last));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
